// File: rtl/sd_spi_byte.sv
// rtl/sd_spi_byte.sv - byte-level SPI mode-0 master owning the SD card pins
// Define SDSPI_CRC7_EN to add the running command CRC7 output spiCRC7.
module sd_spi_byte #(
  parameter int SLOW_DIV   = 63,
  parameter int FAST_DIV   = 2,
  parameter int INIT_BYTES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [0:2] spiOP,
  input  logic [0:7] spiTXD,
  output logic [0:7] spiRXD,
  output logic       spiBUSY,
  output logic       spiDONE,
  input  logic       sdMISO,
  output logic       sdMOSI,
  output logic       sdSCLK,
  output logic       sdCS
`ifdef SDSPI_CRC7_EN
  ,
  output logic [0:6] spiCRC7
`endif
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int DW = $clog2(MAX_DIV + 1);
  localparam int BW = $clog2(INIT_BYTES + 1);
  localparam logic [DW-1:0] SLOW_LOAD = DW'(SLOW_DIV - 1);
  localparam logic [DW-1:0] FAST_LOAD = DW'(FAST_DIV - 1);
  localparam logic [BW-1:0] INIT_LOAD = BW'(INIT_BYTES - 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CSL  = 3'b001;
  localparam logic [2:0] OP_CSH  = 3'b010;
  localparam logic [2:0] OP_FAST = 3'b011;
  localparam logic [2:0] OP_SLOW = 3'b100;
  localparam logic [2:0] OP_TXD  = 3'b101;
  localparam logic [2:0] OP_RXD  = 3'b110;
  localparam logic [2:0] OP_INIT = 3'b111;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t          state;
  logic            fast;
  logic            fast_op;
  logic            byte_op;
  logic [7:0]      shreg;
  logic [7:0]      rxd_q;
  logic [2:0]      bit_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [DW-1:0]   div_cnt;
  logic [DW-1:0]   div_load;
  logic            busy_q;
  logic            done_q;
  logic            sclk_q;
  logic            mosi_q;
  logic            cs_q;

`ifdef SDSPI_CRC7_EN
  logic [6:0] crc_q;
  logic       tx_op;

  // x^7 + x^3 + 1, one message bit per call, MSB first
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign spiCRC7 = crc_q;
`endif

  // Divider reload follows the speed latched at accept, not the live setting
  assign div_load = fast_op ? FAST_LOAD : SLOW_LOAD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fast     <= 1'b0;
      fast_op  <= 1'b0;
      byte_op  <= 1'b0;
      shreg    <= 8'hFF;
      rxd_q    <= 8'h00;
      bit_cnt  <= 3'd7;
      byte_cnt <= '0;
      div_cnt  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      cs_q     <= 1'b1;
`ifdef SDSPI_CRC7_EN
      crc_q    <= 7'h00;
      tx_op    <= 1'b0;
`endif
    end else if (clear) begin
      state  <= IDLE;
      fast   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b1;
      cs_q   <= 1'b1;
`ifdef SDSPI_CRC7_EN
      crc_q  <= 7'h00;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          mosi_q <= 1'b1;
          // busy_q is still high for the cycle after DONE, blocking a back-to-back accept
          if (!busy_q && spiOP != OP_NOP) begin
            busy_q   <= 1'b1;
            fast_op  <= fast;
            div_cnt  <= fast ? FAST_LOAD : SLOW_LOAD;
            bit_cnt  <= 3'd7;
            byte_cnt <= '0;
            byte_op  <= 1'b0;
            state    <= DONE;
`ifdef SDSPI_CRC7_EN
            tx_op    <= (spiOP == OP_TXD);
`endif
            case (spiOP)
              OP_CSL: begin
                cs_q <= 1'b0;
`ifdef SDSPI_CRC7_EN
                crc_q <= 7'h00;
`endif
              end
              OP_CSH:  cs_q <= 1'b1;
              OP_FAST: fast <= 1'b1;
              OP_SLOW: fast <= 1'b0;
              OP_TXD: begin
                shreg   <= spiTXD;
                mosi_q  <= spiTXD[0];
                byte_op <= 1'b1;
                state   <= LOW;
              end
              OP_RXD: begin
                shreg   <= 8'hFF;
                byte_op <= 1'b1;
                state   <= LOW;
              end
              OP_INIT: begin
                shreg    <= 8'hFF;
                cs_q     <= 1'b1;
                byte_cnt <= INIT_LOAD;
                byte_op  <= 1'b1;
                state    <= LOW;
              end
              default: ;
            endcase
          end
        end
        LOW: begin
          if (div_cnt == '0) begin
            div_cnt <= div_load;
            sclk_q  <= 1'b1;
            shreg   <= {shreg[6:0], sdMISO};
`ifdef SDSPI_CRC7_EN
            if (tx_op) crc_q <= crc7_step(crc_q, shreg[7]);
`endif
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        HIGH: begin
          if (div_cnt == '0) begin
            div_cnt <= div_load;
            sclk_q  <= 1'b0;
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
              mosi_q  <= shreg[7];
              state   <= LOW;
            end else if (byte_cnt != '0) begin
              // INIT burst: next 0xFF byte starts with no idle gap
              byte_cnt <= byte_cnt - BW'(1);
              bit_cnt  <= 3'd7;
              shreg    <= 8'hFF;
              mosi_q   <= 1'b1;
              state    <= LOW;
            end else begin
              state <= DONE;
            end
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b1;
          mosi_q <= 1'b1;
          if (byte_op) rxd_q <= shreg;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spiRXD  = rxd_q;
  assign spiBUSY = busy_q;
  assign spiDONE = done_q;
  assign sdSCLK  = sclk_q;
  assign sdMOSI  = mosi_q;
  assign sdCS    = cs_q;

endmodule
